// File: rtl/run_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : run_seq_gen
// Purpose  : Serial run-length stream generator. On an accepted start it
//            emits a run of zero bits followed by a run of one bits, with
//            lengths latched at start, and flags the final bit of each run
//            on `last` (feeds the run detector's run-complete strobe `c`).
// Ports    : Clock    - rising-edge system clock
//            Reset    - asynchronous active-high reset
//            start    - begin a sequence (sampled only in IDLE)
//            zero_len - zero-run length (0 is treated as 1)
//            one_len  - one-run length (0 is treated as 1)
//            loop     - repeat sequence (only with RUN_SEQ_LOOP_EN)
//            w        - serial data bit
//            valid    - w carries a stream bit this cycle
//            last     - final bit of the current run
//            busy     - any state other than IDLE
//            done     - one-cycle pulse after the final one-bit
// Options  : RUN_SEQ_LOOP_EN - adds the `loop` port and back-to-back repeat
// Revision : 1.0 - initial release
// ============================================================================
module run_seq_gen #(
    parameter int CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic [CNT_W-1:0] zero_len,
    input  logic [CNT_W-1:0] one_len,
`ifdef RUN_SEQ_LOOP_EN
    input  logic             loop,
`endif
    output logic             w,
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ZEROS = 2'd1,
        ONES  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] zl_q, zl_next;
    logic [CNT_W-1:0] ol_q, ol_next;
    logic [CNT_W-1:0] zero_len_c;
    logic [CNT_W-1:0] one_len_c;
    logic             loop_go;

    // A zero-length run is still one bit long, so clamp before latching.
    assign zero_len_c = (zero_len == '0) ? ONE : zero_len;
    assign one_len_c  = (one_len  == '0) ? ONE : one_len;

`ifdef RUN_SEQ_LOOP_EN
    assign loop_go = loop;
`else
    assign loop_go = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            zl_q  <= '0;
            ol_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            zl_q  <= zl_next;
            ol_q  <= ol_next;
        end
    end

    // Outputs are decoded from state/cnt only, so reset clears them at once
    // and no input reaches an output combinationally.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        zl_next    = zl_q;
        ol_next    = ol_q;
        w          = 1'b0;
        valid      = 1'b0;
        last       = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    zl_next    = zero_len_c;
                    ol_next    = one_len_c;
                    cnt_next   = zero_len_c - ONE;
                    state_next = ZEROS;
                end
            end
            ZEROS: begin
                valid = 1'b1;
                last  = (cnt == '0);
                if (cnt != '0) begin
                    cnt_next = cnt - ONE;
                end else begin
                    cnt_next   = ol_q - ONE;
                    state_next = ONES;
                end
            end
            ONES: begin
                w     = 1'b1;
                valid = 1'b1;
                last  = (cnt == '0);
                if (cnt != '0) begin
                    cnt_next = cnt - ONE;
                end else if (loop_go) begin
                    // Restart straight into the zero run; no DONE gap.
                    cnt_next   = zl_q - ONE;
                    state_next = ZEROS;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_run_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_seq_gen
// Purpose  : Directed self-checking bench for run_seq_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_seq_gen;

    localparam int CNT_W = 4;

    logic             Clock;
    logic             Reset;
    logic             start;
    logic [CNT_W-1:0] zero_len;
    logic [CNT_W-1:0] one_len;
`ifdef RUN_SEQ_LOOP_EN
    logic             loop;
`endif
    logic             w, valid, last, busy, done;

    int checks = 0;
    int errors = 0;

    run_seq_gen #(.CNT_W(CNT_W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .start    (start),
        .zero_len (zero_len),
        .one_len  (one_len),
`ifdef RUN_SEQ_LOOP_EN
        .loop     (loop),
`endif
        .w        (w),
        .valid    (valid),
        .last     (last),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output vector order: {w, valid, last, busy, done}
    task automatic check_out(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, w, valid, last, busy, done}, {27'd0, exp});
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Starts a frame from IDLE and checks every cycle through the return to
    // IDLE. ez/eo are the expected (clamped) run lengths. With disturb set,
    // start is re-pulsed and the length inputs changed mid-zero-run.
    task automatic run_frame(input string tag, input logic [CNT_W-1:0] zl,
                             input logic [CNT_W-1:0] ol, input int ez,
                             input int eo, input bit disturb);
        zero_len = zl;
        one_len  = ol;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < ez; i++) begin
            check_out({tag, "_zero"}, {1'b0, 1'b1, (i == ez - 1), 1'b1, 1'b0});
            if (disturb && i == 3) begin
                start    = 1'b1;
                zero_len = 4'd2;
                one_len  = 4'd1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        for (int i = 0; i < eo; i++) begin
            check_out({tag, "_one"}, {1'b1, 1'b1, (i == eo - 1), 1'b1, 1'b0});
            step();
        end
        check_out({tag, "_done"}, 5'b00011);
        step();
        check_out({tag, "_idle"}, 5'b00000);
    endtask

    initial begin
        Reset    = 1'b1;
        start    = 1'b0;
        zero_len = '0;
        one_len  = '0;
`ifdef RUN_SEQ_LOOP_EN
        loop     = 1'b0;
`endif
        step();
        step();
        check_out("reset_state", 5'b00000);
        Reset = 1'b0;
        step();
        check_out("idle_after_reset", 5'b00000);

        // Asynchronous reset in the middle of a zero run.
        zero_len = 4'd5;
        one_len  = 4'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        check_out("pre_reset_zeros", 5'b01010);
        #2;
        Reset = 1'b1;
        #1;
        check_out("async_reset", 5'b00000);
        step();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("post_reset_idle", 5'b00000);
        end

        run_frame("f3_2", 4'd3, 4'd2, 3, 2, 1'b0);
        step();
        run_frame("f0_0", 4'd0, 4'd0, 1, 1, 1'b0);
        step();
        run_frame("f15_15", 4'd15, 4'd15, 15, 15, 1'b1);
        step();
        run_frame("f1_4", 4'd1, 4'd4, 1, 4, 1'b0);

        // start held high: frames 0,0,1,(done),(idle) back to back.
        zero_len = 4'd2;
        one_len  = 4'd1;
        start    = 1'b1;
        step();
        for (int f = 0; f < 3; f++) begin
            check_out("held_z1", 5'b01010);
            step();
            check_out("held_z2", 5'b01110);
            step();
            check_out("held_o1", 5'b11110);
            step();
            check_out("held_done", 5'b00011);
            step();
            check_out("held_idle", 5'b00000);
            if (f == 2) start = 1'b0;
            step();
        end
        check_out("held_stop", 5'b00000);

`ifdef RUN_SEQ_LOOP_EN
        // Lengths 1/2, loop for two frames, then a final single-shot frame.
        zero_len = 4'd1;
        one_len  = 4'd2;
        loop     = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 6) loop = 1'b0;
            check_out("loop_bit", {((i % 3) != 0), 1'b1, ((i % 3) != 1), 1'b1, 1'b0});
            step();
        end
        check_out("loop_done", 5'b00011);
        step();
        check_out("loop_idle", 5'b00000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
